// File: rtl/spi_slave_axis.sv
// spi_slave_axis: SPI mode-0 target (MSB first, 8-bit words) that terminates an
// external initiator inside the aclk domain. All SPI pins are oversampled.
// Received bytes leave on rx_axis (AXI4-Stream master). Bytes returned to the
// initiator arrive on tx_axis (AXI4-Stream slave).
// Optional build macro SPI_SLAVE_FRAME_CNT_EN adds frame_done/frame_bytes.
module spi_slave_axis #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  FILL_BYTE   = 8'hFF
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        spi_csn,
    input  logic        spi_sck,
    input  logic        spi_sdi,
    output logic        spi_sdo,
    output logic        rx_axis_tvalid,
    input  logic        rx_axis_tready,
    output logic [7:0]  rx_axis_tdata,
    output logic        rx_axis_tuser,
    input  logic        tx_axis_tvalid,
    output logic        tx_axis_tready,
    input  logic [7:0]  tx_axis_tdata,
    output logic        rx_overrun
`ifdef SPI_SLAVE_FRAME_CNT_EN
    ,
    output logic        frame_done,
    output logic [15:0] frame_bytes
`endif
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] csn_sync, sck_sync, sdi_sync, sync_live;
    logic csn_s, sck_s, sdi_s;
    logic csn_d, sck_d, csn_armed;
    logic csn_fall_q, csn_rise_q, sck_rise_q, sck_fall_q, sdi_q;

    logic       start, stop, shift_in, shift_out, byte_end, fetch;
    logic [7:0] tx_next;
    logic       rx_accept;

    logic [2:0] bit_cnt;
    logic [6:0] rx_shift;
    logic [6:0] tx_shift;
    logic [7:0] tx_hold;
    logic       first;

    logic       byte_done;
    logic [7:0] byte_val;
    logic       byte_first;

    assign csn_s = csn_sync[SYNC_STAGES-1];
    assign sck_s = sck_sync[SYNC_STAGES-1];
    assign sdi_s = sdi_sync[SYNC_STAGES-1];

    // Pin synchronizers; sync_live marks which stages hold post-reset samples.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            csn_sync  <= '1;
            sck_sync  <= '0;
            sdi_sync  <= '0;
            sync_live <= '0;
        end else begin
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi};
            sync_live <= {sync_live[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Edge detection against a delayed copy; pulses and sdi are registered together.
    // csn falls are only honoured once a genuine high csn has been seen after reset,
    // so a csn held low through reset never opens a frame.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            csn_d      <= 1'b1;
            sck_d      <= 1'b0;
            csn_armed  <= 1'b0;
            csn_fall_q <= 1'b0;
            csn_rise_q <= 1'b0;
            sck_rise_q <= 1'b0;
            sck_fall_q <= 1'b0;
            sdi_q      <= 1'b0;
        end else begin
            csn_d      <= csn_s;
            sck_d      <= sck_s;
            csn_armed  <= csn_armed | (sync_live[SYNC_STAGES-1] & csn_s);
            csn_fall_q <= csn_armed & csn_d & ~csn_s;
            csn_rise_q <= ~csn_d & csn_s;
            sck_rise_q <= ~sck_d & sck_s;
            sck_fall_q <= sck_d & ~sck_s;
            sdi_q      <= sdi_s;
        end
    end

    // Frame state register.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-cycle control strobes; tready pulses on each tx fetch.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        stop       = 1'b0;
        shift_in   = 1'b0;
        shift_out  = 1'b0;
        case (state)
            IDLE: begin
                if (csn_fall_q) begin
                    start      = 1'b1;
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (csn_rise_q) begin
                    stop       = 1'b1;
                    state_next = IDLE;
                end else begin
                    shift_in  = sck_rise_q;
                    shift_out = sck_fall_q;
                end
            end
            default: state_next = IDLE;
        endcase
        byte_end       = shift_in & (bit_cnt == 3'd7);
        fetch          = start | byte_end;
        tx_next        = tx_axis_tvalid ? tx_axis_tdata : FILL_BYTE;
        tx_axis_tready = fetch & tx_axis_tvalid;
        rx_accept      = ~rx_axis_tvalid | rx_axis_tready;
    end

    // Shift datapath. spi_sdo itself carries bit 7 of the transmit word, so
    // tx_shift only keeps the seven bits still waiting behind it.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
            tx_hold  <= '0;
            spi_sdo  <= 1'b0;
        end else if (start) begin
            bit_cnt  <= '0;
            tx_shift <= tx_next[6:0];
            spi_sdo  <= tx_next[7];
        end else if (stop) begin
            bit_cnt  <= '0;
            spi_sdo  <= 1'b0;
        end else begin
            if (shift_in) begin
                rx_shift <= {rx_shift[5:0], sdi_q};
                bit_cnt  <= bit_cnt + 3'd1;
            end
            if (byte_end) begin
                tx_hold <= tx_next;
            end
            if (shift_out) begin
                if (bit_cnt != 3'd0) begin
                    tx_shift <= {tx_shift[5:0], 1'b0};
                    spi_sdo  <= tx_shift[6];
                end else begin
                    tx_shift <= tx_hold[6:0];
                    spi_sdo  <= tx_hold[7];
                end
            end
        end
    end

    // Completed-byte stage and first-of-frame tracking.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            byte_done  <= 1'b0;
            byte_val   <= '0;
            byte_first <= 1'b0;
            first      <= 1'b0;
        end else begin
            byte_done <= byte_end;
            if (byte_end) begin
                byte_val   <= {rx_shift, sdi_q};
                byte_first <= first;
            end
            if (start) begin
                first <= 1'b1;
            end else if (byte_done && rx_accept) begin
                first <= 1'b0;
            end
        end
    end

    // rx_axis holding register: new byte replaces on accept, else dropped with overrun.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rx_axis_tvalid <= 1'b0;
            rx_axis_tdata  <= '0;
            rx_axis_tuser  <= 1'b0;
            rx_overrun     <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;
            if (byte_done) begin
                if (rx_accept) begin
                    rx_axis_tdata  <= byte_val;
                    rx_axis_tuser  <= byte_first;
                    rx_axis_tvalid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_axis_tready) begin
                rx_axis_tvalid <= 1'b0;
            end
        end
    end

`ifdef SPI_SLAVE_FRAME_CNT_EN
    logic [15:0] byte_cnt;

    // Per-frame completed-byte count (dropped bytes included), published at frame end.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            byte_cnt    <= '0;
            frame_done  <= 1'b0;
            frame_bytes <= '0;
        end else begin
            frame_done <= stop;
            if (start) begin
                byte_cnt <= '0;
            end else if (byte_end && byte_cnt != 16'hFFFF) begin
                byte_cnt <= byte_cnt + 16'd1;
            end
            if (stop) begin
                frame_bytes <= byte_cnt;
            end
        end
    end
`else
    // No frame statistics in this build.
`endif

endmodule

// File: tb/tb_spi_slave_axis.sv
// tb_spi_slave_axis: directed self-checking bench for spi_slave_axis.
// Acts as the SPI initiator (mode 0) plus AXI-Stream source/sink.
// Frame statistics are checked when SPI_SLAVE_FRAME_CNT_EN is defined.
module tb_spi_slave_axis;

    localparam int SYNC = 2;
    localparam int HALF = 6;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic       spi_csn = 1'b1;
    logic       spi_sck = 1'b0;
    logic       spi_sdi = 1'b0;
    logic       spi_sdo;
    logic       rx_axis_tvalid;
    logic       rx_axis_tready = 1'b1;
    logic [7:0] rx_axis_tdata;
    logic       rx_axis_tuser;
    logic       tx_axis_tvalid = 1'b0;
    logic       tx_axis_tready;
    logic [7:0] tx_axis_tdata = 8'h00;
    logic       rx_overrun;
`ifdef SPI_SLAVE_FRAME_CNT_EN
    logic        frame_done;
    logic [15:0] frame_bytes;
`endif

    always #5 aclk = ~aclk;

    spi_slave_axis #(
        .SYNC_STAGES(SYNC),
        .FILL_BYTE  (8'hFF)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .spi_csn       (spi_csn),
        .spi_sck       (spi_sck),
        .spi_sdi       (spi_sdi),
        .spi_sdo       (spi_sdo),
        .rx_axis_tvalid(rx_axis_tvalid),
        .rx_axis_tready(rx_axis_tready),
        .rx_axis_tdata (rx_axis_tdata),
        .rx_axis_tuser (rx_axis_tuser),
        .tx_axis_tvalid(tx_axis_tvalid),
        .tx_axis_tready(tx_axis_tready),
        .tx_axis_tdata (tx_axis_tdata),
        .rx_overrun    (rx_overrun)
`ifdef SPI_SLAVE_FRAME_CNT_EN
        ,
        .frame_done    (frame_done),
        .frame_bytes   (frame_bytes)
`endif
    );

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    logic [8:0] rx_q[$];
    int tx_hs = 0;
    int ovr_cnt = 0;
    int fd_cnt = 0;

    // Handshake/pulse monitor, sampled mid-cycle.
    always @(negedge aclk) begin
        if (aresetn && rx_axis_tvalid && rx_axis_tready) rx_q.push_back({rx_axis_tuser, rx_axis_tdata});
        if (aresetn && tx_axis_tvalid && tx_axis_tready) tx_hs++;
        if (aresetn && rx_overrun) ovr_cnt++;
`ifdef SPI_SLAVE_FRAME_CNT_EN
        if (aresetn && frame_done) fd_cnt++;
`endif
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic spi_start();
        spi_csn = 1'b0;
        step(8);
    endtask

    task automatic spi_stop();
        step(HALF);
        spi_csn = 1'b1;
        step(12);
    endtask

    // Shift nbits (MSB first) of mosi; returns sampled miso and the rx_tvalid
    // latency after the 8th rising sck (-1 if not observed).
    task automatic spi_xfer(input logic [7:0] mosi, input int nbits,
                            output logic [7:0] miso, output int lat);
        logic was;
        miso = '0;
        lat  = -1;
        for (int i = 7; i >= 8 - nbits; i--) begin
            spi_sdi = mosi[i];
            step(HALF);
            miso[i] = spi_sdo;
            spi_sck = 1'b1;
            if (i == 0) begin
                was = rx_axis_tvalid;
                for (int k = 1; k <= HALF; k++) begin
                    step(1);
                    if (lat < 0 && !was && rx_axis_tvalid) lat = k - 1;
                end
            end else begin
                step(HALF);
            end
            spi_sck = 1'b0;
        end
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_sdo"},    32'(spi_sdo),        32'd0);
        chk({pfx, "_tvalid"}, 32'(rx_axis_tvalid), 32'd0);
        chk({pfx, "_tdata"},  32'(rx_axis_tdata),  32'd0);
        chk({pfx, "_tuser"},  32'(rx_axis_tuser),  32'd0);
        chk({pfx, "_tready"}, 32'(tx_axis_tready), 32'd0);
        chk({pfx, "_ovr"},    32'(rx_overrun),     32'd0);
    endtask

    initial begin
        logic [7:0] miso;
        int lat, nq, hs0, ov0, fd0;

        // Reset
        step(4);
        chk_reset_outputs("rst");
        aresetn = 1'b1;
        step(SYNC + 4);

        // 1: tx preloaded A5, initiator sends 3C
        nq = rx_q.size(); hs0 = tx_hs; ov0 = ovr_cnt; fd0 = fd_cnt;
        tx_axis_tdata  = 8'hA5;
        tx_axis_tvalid = 1'b1;
        spi_start();
        tx_axis_tvalid = 1'b0;
        spi_xfer(8'h3C, 8, miso, lat);
        spi_stop();
        chk("t1_miso", 32'(miso), 32'hA5);
        chk("t1_latency", 32'(lat), 32'(SYNC + 2));
        chk("t1_rx_count", 32'(rx_q.size() - nq), 32'd1);
        chk("t1_rx0", 32'(rx_q[nq]), {23'd0, 1'b1, 8'h3C});
        chk("t1_tready_pulses", 32'(tx_hs - hs0), 32'd1);
        chk("t1_overrun", 32'(ovr_cnt - ov0), 32'd0);
        chk("t1_sdo_idle", 32'(spi_sdo), 32'd0);
`ifdef SPI_SLAVE_FRAME_CNT_EN
        chk("t1_frame_done", 32'(fd_cnt - fd0), 32'd1);
        chk("t1_frame_bytes", 32'(frame_bytes), 32'd1);
`endif

        // 2: three-byte frame, tx idle
        nq = rx_q.size(); hs0 = tx_hs;
        spi_start();
        spi_xfer(8'h01, 8, miso, lat);
        chk("t2_miso0", 32'(miso), 32'hFF);
        spi_xfer(8'h02, 8, miso, lat);
        chk("t2_miso1", 32'(miso), 32'hFF);
        spi_xfer(8'h03, 8, miso, lat);
        chk("t2_miso2", 32'(miso), 32'hFF);
        spi_stop();
        chk("t2_rx_count", 32'(rx_q.size() - nq), 32'd3);
        chk("t2_rx0", 32'(rx_q[nq]),     {23'd0, 1'b1, 8'h01});
        chk("t2_rx1", 32'(rx_q[nq + 1]), {23'd0, 1'b0, 8'h02});
        chk("t2_rx2", 32'(rx_q[nq + 2]), {23'd0, 1'b0, 8'h03});
        chk("t2_tready_pulses", 32'(tx_hs - hs0), 32'd0);
`ifdef SPI_SLAVE_FRAME_CNT_EN
        chk("t2_frame_bytes", 32'(frame_bytes), 32'd3);
`endif

        // 3: rx_tready held low over two bytes -> overrun on the second
        nq = rx_q.size(); ov0 = ovr_cnt;
        rx_axis_tready = 1'b0;
        spi_start();
        spi_xfer(8'h11, 8, miso, lat);
        spi_xfer(8'h22, 8, miso, lat);
        spi_stop();
        chk("t3_tvalid_held", 32'(rx_axis_tvalid), 32'd1);
        chk("t3_tdata_held", 32'(rx_axis_tdata), 32'h11);
        chk("t3_tuser_held", 32'(rx_axis_tuser), 32'd1);
        chk("t3_overrun", 32'(ovr_cnt - ov0), 32'd1);
        rx_axis_tready = 1'b1;
        step(3);
        chk("t3_tvalid_clear", 32'(rx_axis_tvalid), 32'd0);
        chk("t3_rx_count", 32'(rx_q.size() - nq), 32'd1);
        chk("t3_rx0", 32'(rx_q[nq]), {23'd0, 1'b1, 8'h11});
`ifdef SPI_SLAVE_FRAME_CNT_EN
        chk("t3_frame_bytes", 32'(frame_bytes), 32'd2);
`endif

        // 4: aborted partial byte, then a full byte in a new frame
        nq = rx_q.size(); ov0 = ovr_cnt;
        spi_start();
        spi_xfer(8'hF0, 4, miso, lat);
        spi_stop();
        chk("t4_partial_none", 32'(rx_q.size() - nq), 32'd0);
`ifdef SPI_SLAVE_FRAME_CNT_EN
        chk("t4_partial_frame_bytes", 32'(frame_bytes), 32'd0);
`endif
        spi_start();
        spi_xfer(8'h5A, 8, miso, lat);
        spi_stop();
        chk("t4_rx_count", 32'(rx_q.size() - nq), 32'd1);
        chk("t4_rx0", 32'(rx_q[nq]), {23'd0, 1'b1, 8'h5A});
        chk("t4_overrun", 32'(ovr_cnt - ov0), 32'd0);

        // 5: reset mid-byte with csn low; no frame until csn toggles
        spi_start();
        spi_xfer(8'hAA, 4, miso, lat);
        aresetn = 1'b0;
        step(3);
        chk_reset_outputs("t5_rst");
        aresetn = 1'b1;
        step(SYNC + 4);
        nq = rx_q.size(); hs0 = tx_hs;
        tx_axis_tdata  = 8'h96;
        tx_axis_tvalid = 1'b1;
        spi_xfer(8'h77, 8, miso, lat);
        step(12);
        chk("t5_nocsn_miso", 32'(miso), 32'h00);
        chk("t5_nocsn_rx", 32'(rx_q.size() - nq), 32'd0);
        chk("t5_nocsn_tready", 32'(tx_hs - hs0), 32'd0);
        spi_stop();
        spi_start();
        tx_axis_tvalid = 1'b0;
        chk("t5_tready_pulses", 32'(tx_hs - hs0), 32'd1);
        spi_xfer(8'hC3, 8, miso, lat);
        spi_stop();
        chk("t5_miso", 32'(miso), 32'h96);
        chk("t5_rx_count", 32'(rx_q.size() - nq), 32'd1);
        chk("t5_rx0", 32'(rx_q[nq]), {23'd0, 1'b1, 8'hC3});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
